// File: rtl/sb_cfg_bank.sv
// Double-buffered switch-block configuration bank: word writes land in a shadow
// store, an atomic commit copies shadow to the active store that drives the muxes.
module sb_cfg_bank #(
  parameter int unsigned          NUM_MUX     = 21,
  parameter int unsigned          SRAM_BITS   = 6,
  parameter int unsigned          ADDR_W      = $clog2(NUM_MUX),
  parameter logic [SRAM_BITS-1:0] RESET_VALUE = '0
) (
  input  logic                           prog_clk,
  input  logic                           pReset,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic                           cfg_write,
  input  logic [ADDR_W-1:0]              cfg_addr,
  input  logic [SRAM_BITS-1:0]           cfg_data,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [SRAM_BITS-1:0]           rd_data,
  input  logic                           commit,
  output logic                           commit_done,
  output logic                           err_addr,
  input  logic                           err_clr,
  output logic [NUM_MUX*SRAM_BITS-1:0]   sram,
  output logic [NUM_MUX*SRAM_BITS-1:0]   sram_inv
);

  localparam int unsigned BUS_W = NUM_MUX * SRAM_BITS;
  localparam logic [ADDR_W:0] MUX_LIM = (ADDR_W+1)'(NUM_MUX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 ready_en_q;
  logic                 commit_pend_q, commit_pend_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [SRAM_BITS-1:0] rd_data_q, rd_data_d;
  logic                 commit_done_q, commit_done_d;
  logic                 err_addr_q, err_addr_d;
  logic [SRAM_BITS-1:0] shadow_q [NUM_MUX];
  logic [SRAM_BITS-1:0] shadow_d [NUM_MUX];
  logic [BUS_W-1:0]     active_q, active_d;

  logic                 addr_ok;
  logic                 req_acc, wr_acc, rd_acc, rd_done;
  logic [SRAM_BITS-1:0] rd_word;

  // ready_en_q holds cfg_ready low for the first edge after reset release
  assign cfg_ready = ready_en_q & (state_q == ST_IDLE) & ~commit_pend_q;
  assign addr_ok   = {1'b0, cfg_addr} < MUX_LIM;
  assign req_acc   = cfg_valid & cfg_ready;
  assign wr_acc    = req_acc & cfg_write;
  assign rd_acc    = req_acc & ~cfg_write;
  assign rd_done   = rd_valid_q & rd_ready;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < int'(NUM_MUX); i++) begin
      if (cfg_addr == ADDR_W'(i)) rd_word = shadow_q[i];
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_acc)      state_d = ST_READ;
        else if (commit) state_d = ST_COMMIT;
      end
      ST_READ: begin
        if (rd_done) state_d = (commit_pend_q | commit) ? ST_COMMIT : ST_IDLE;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shadow_d      = shadow_q;
    active_d      = active_q;
    rd_valid_d    = rd_valid_q;
    rd_data_d     = rd_data_q;
    commit_pend_d = commit_pend_q;
    commit_done_d = 1'b0;
    err_addr_d    = err_addr_q;

    // a new out-of-range access wins over a same-cycle clear
    if (err_clr)              err_addr_d = 1'b0;
    if (req_acc && !addr_ok)  err_addr_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (wr_acc && addr_ok) begin
          for (int i = 0; i < int'(NUM_MUX); i++) begin
            if (cfg_addr == ADDR_W'(i)) shadow_d[i] = cfg_data;
          end
        end
        if (rd_acc) begin
          rd_valid_d = 1'b1;
          rd_data_d  = addr_ok ? rd_word : '0;
          if (commit) commit_pend_d = 1'b1;
        end
      end
      ST_READ: begin
        if (rd_done) begin
          rd_valid_d    = 1'b0;
          commit_pend_d = 1'b0;
        end else if (commit) begin
          commit_pend_d = 1'b1;
        end
      end
      ST_COMMIT: begin
        for (int i = 0; i < int'(NUM_MUX); i++) begin
          active_d[i*SRAM_BITS +: SRAM_BITS] = shadow_q[i];
        end
        commit_done_d = 1'b1;
        commit_pend_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      ready_en_q    <= 1'b0;
      commit_pend_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      commit_done_q <= 1'b0;
      err_addr_q    <= 1'b0;
      active_q      <= {NUM_MUX{RESET_VALUE}};
      for (int i = 0; i < int'(NUM_MUX); i++) shadow_q[i] <= RESET_VALUE;
    end else begin
      ready_en_q    <= 1'b1;
      commit_pend_q <= commit_pend_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      commit_done_q <= commit_done_d;
      err_addr_q    <= err_addr_d;
      active_q      <= active_d;
      for (int i = 0; i < int'(NUM_MUX); i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign commit_done = commit_done_q;
  assign err_addr    = err_addr_q;
  assign sram        = active_q;
  assign sram_inv    = ~active_q;

endmodule

// File: tb/tb_sb_cfg_bank.sv
// Bench for sb_cfg_bank: reference shadow/active model plus a readback scoreboard queue.
module tb_sb_cfg_bank;

  localparam int unsigned NM = 21;
  localparam int unsigned SB = 6;
  localparam int unsigned AW = 5;
  localparam int unsigned BW = NM * SB;

  logic          prog_clk;
  logic          pReset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_write;
  logic [AW-1:0] cfg_addr;
  logic [SB-1:0] cfg_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [SB-1:0] rd_data;
  logic          commit;
  logic          commit_done;
  logic          err_addr;
  logic          err_clr;
  logic [BW-1:0] sram;
  logic [BW-1:0] sram_inv;

  sb_cfg_bank #(.NUM_MUX(NM), .SRAM_BITS(SB)) dut (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_write   (cfg_write),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .commit      (commit),
    .commit_done (commit_done),
    .err_addr    (err_addr),
    .err_clr     (err_clr),
    .sram        (sram),
    .sram_inv    (sram_inv)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [SB-1:0] data;
    logic [SB-1:0] exp_rd;
  } vec_t;

  vec_t          tbl [7];
  logic [SB-1:0] shadow_m [NM];
  logic [SB-1:0] active_m [NM];
  logic          err_m;
  logic [SB-1:0] exp_q [$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_sram();
    logic [BW-1:0] v;
    for (int i = 0; i < int'(NM); i++) v[i*SB +: SB] = active_m[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NM); i++) begin
      shadow_m[i] = '0;
      active_m[i] = '0;
    end
    err_m = 1'b0;
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic check_bus(input string nm);
    logic [BW-1:0] e, ei;
    e  = exp_sram();
    ei = ~e;
    chk({nm, "_sram"}, sram, e);
    chk({nm, "_sram_inv"}, sram_inv, ei);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (cfg_ready !== 1'b1) chk("cfg_ready_wait", cfg_ready, 1);
  endtask

  // entered with the DUT in COMMIT: checks the pulse and the active store update
  task automatic commit_tail(input string nm);
    chk({nm, "_done_early"}, commit_done, 0);
    tick();
    for (int i = 0; i < int'(NM); i++) active_m[i] = shadow_m[i];
    chk({nm, "_done"}, commit_done, 1);
    check_bus(nm);
    tick();
    chk({nm, "_done_off"}, commit_done, 0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [SB-1:0] d,
                    input logic with_commit, input logic clr);
    wait_ready();
    cfg_valid = 1'b1;
    cfg_write = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    commit    = with_commit;
    err_clr   = clr;
    tick();
    cfg_valid = 1'b0;
    commit    = 1'b0;
    err_clr   = 1'b0;
    if (int'(a) < int'(NM)) shadow_m[a] = d;
    if (int'(a) >= int'(NM)) err_m = 1'b1;
    else if (clr)            err_m = 1'b0;
    chk("wr_err_addr", err_addr, err_m);
    if (with_commit) commit_tail("wr_commit");
  endtask

  task automatic commit_pulse(input string nm);
    wait_ready();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    commit_tail(nm);
  endtask

  task automatic rd(input logic [AW-1:0] a, input int hold, input int commit_at);
    wait_ready();
    exp_q.push_back((int'(a) < int'(NM)) ? shadow_m[a] : 6'h00);
    cfg_valid = 1'b1;
    cfg_write = 1'b0;
    cfg_addr  = a;
    tick();
    cfg_valid = 1'b0;
    if (int'(a) >= int'(NM)) err_m = 1'b1;
    chk("rd_valid_rise", rd_valid, 1);
    chk("rd_err_addr", err_addr, err_m);
    for (int h = 0; h < hold; h++) begin
      commit = (h == commit_at);
      tick();
      commit = 1'b0;
      chk("rd_hold_valid", rd_valid, 1);
      chk("rd_hold_data", rd_data, exp_q[0]);
      chk("rd_hold_ready", cfg_ready, 0);
    end
    rd_ready = 1'b1;
    chk("rd_data", rd_data, exp_q.pop_front());
    tick();
    rd_ready = 1'b0;
    chk("rd_valid_fall", rd_valid, 0);
    if (commit_at >= 0) commit_tail("rd_pend_commit");
    else                chk("rd_back_idle", cfg_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    pReset    = 1'b1;
    cfg_valid = 1'b0;
    cfg_write = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    rd_ready  = 1'b0;
    commit    = 1'b0;
    err_clr   = 1'b0;
    model_reset();

    tbl[0] = '{addr: 5'd1,  data: 6'h07, exp_rd: 6'h07};
    tbl[1] = '{addr: 5'd2,  data: 6'h38, exp_rd: 6'h38};
    tbl[2] = '{addr: 5'd9,  data: 6'h2C, exp_rd: 6'h2C};
    tbl[3] = '{addr: 5'd14, data: 6'h3F, exp_rd: 6'h3F};
    tbl[4] = '{addr: 5'd19, data: 6'h01, exp_rd: 6'h01};
    tbl[5] = '{addr: 5'd0,  data: 6'h1E, exp_rd: 6'h1E};
    tbl[6] = '{addr: 5'd31, data: 6'h2A, exp_rd: 6'h00};

    // reset state and cfg_ready release timing
    tick();
    tick();
    check_bus("reset");
    chk("reset_cfg_ready", cfg_ready, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_commit_done", commit_done, 0);
    chk("reset_err_addr", err_addr, 0);
    pReset = 1'b0;
    #1;
    chk("release_cfg_ready_low", cfg_ready, 0);
    tick();
    chk("release_cfg_ready_high", cfg_ready, 1);

    // back-to-back writes leave the active store alone until commit
    wr(5'd3, 6'h2A, 1'b0, 1'b0);
    wr(5'd20, 6'h15, 1'b0, 1'b0);
    check_bus("pre_commit");
    commit_pulse("commit1");
    chk("mux3_slice", sram[18 +: 6], 6'h2A);
    chk("mux20_slice", sram[120 +: 6], 6'h15);

    // readback stalled by rd_ready
    rd(5'd3, 5, -1);

    // commit raised during READ is deferred until the read handshake
    wr(5'd5, 6'h11, 1'b0, 1'b0);
    rd(5'd5, 3, 1);
    chk("mux5_slice", sram[30 +: 6], 6'h11);

    // out-of-range accesses
    wr(5'd21, 6'h3F, 1'b0, 1'b0);
    rd(5'd25, 0, -1);
    commit_pulse("oor_commit");
    wr(5'd30, 6'h00, 1'b0, 1'b1);
    chk("err_clr_loses", err_addr, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    err_m   = 1'b0;
    chk("err_clr", err_addr, 0);

    // table: write all, commit, read each back and check its active slice
    for (int v = 0; v < 7; v++) wr(tbl[v].addr, tbl[v].data, 1'b0, 1'b0);
    commit_pulse("tbl_commit");
    for (int v = 0; v < 7; v++) begin
      rd(tbl[v].addr, 1, -1);
      chk("tbl_rd_expect", rd_data, tbl[v].exp_rd);
      if (int'(tbl[v].addr) < int'(NM))
        chk("tbl_slice", sram[int'(tbl[v].addr)*SB +: SB], tbl[v].data);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    err_m   = 1'b0;
    chk("tbl_err_clr", err_addr, 0);

    // commit held high re-commits every other cycle
    wr(5'd7, 6'h33, 1'b0, 1'b0);
    pulses = 0;
    commit = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 5) commit = 1'b0;
      if (commit_done === 1'b1) pulses++;
    end
    for (int i = 0; i < int'(NM); i++) active_m[i] = shadow_m[i];
    chk("held_commit_pulses", pulses, 3);
    check_bus("held_commit");

    // write with same-cycle commit, then reset while in COMMIT
    wr(5'd0, 6'h01, 1'b1, 1'b0);
    chk("mux0_slice", sram[0 +: 6], 6'h01);
    wr(5'd8, 6'h2B, 1'b0, 1'b0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    pReset = 1'b1;
    #1;
    model_reset();
    check_bus("reset_in_commit");
    chk("rst_commit_done", commit_done, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    tick();
    pReset = 1'b0;
    tick();
    chk("rst_release_ready", cfg_ready, 1);
    rd(5'd0, 0, -1);
    commit_pulse("post_reset_commit");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
